// File: rtl/adc_window_accumulator_pkg.sv
// ============================================================================
// adc_window_accumulator_pkg : shared widths and FSM encoding for the ADC
// window accumulator.                                     Revision: 1.0
// ============================================================================
`default_nettype none

package adc_window_accumulator_pkg;

  localparam int ADC_WIDTH    = 8;
  localparam int ADC_MIDSCALE = 128;
  localparam int SQ_WIDTH     = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_window_accumulator_cs_edge_sync.sv
// ============================================================================
// cs_edge_sync : two-flop synchroniser plus rising-edge pulse for an
// asynchronous strobe input.                              Revision: 1.0
// ============================================================================
`default_nettype none

module cs_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pulse = sync2 & ~sync3;

endmodule

`default_nettype wire

// File: rtl/adc_window_accumulator.sv
// ============================================================================
// adc_window_accumulator : per-window mean, mean-square and peaks of offset-
// removed ADC samples over 2**N_LOG2 conversions.          Revision: 1.0
// ============================================================================
`default_nettype none

module adc_window_accumulator
  import adc_window_accumulator_pkg::*;
#(
  parameter int N_LOG2 = 6,
  parameter int OFFSET = ADC_MIDSCALE
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 CS,
  input  logic [ADC_WIDTH-1:0] ADC_value,
  output logic [ADC_WIDTH-1:0] mean,
  output logic [SQ_WIDTH-1:0]  mean_sq,
  output logic [ADC_WIDTH-1:0] peak_max,
  output logic [ADC_WIDTH-1:0] peak_min,
  output logic                 result_valid
);

  localparam int SUM_W   = ADC_WIDTH + 1 + N_LOG2;
  localparam int SUMSQ_W = SQ_WIDTH + N_LOG2;
  localparam int PROD_W  = 2 * ADC_WIDTH;

  state_t state;
  state_t state_next;

  logic                     strobe;
  logic signed [ADC_WIDTH:0] s;
  logic [ADC_WIDTH-1:0]     mag;
  logic [PROD_W-1:0]        sq_full;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         sum_final;
  logic [SUMSQ_W-1:0]       sumsq;
  logic [SUMSQ_W-1:0]       sumsq_final;
  logic [ADC_WIDTH-1:0]     run_min;
  logic [ADC_WIDTH-1:0]     run_max;
  logic [ADC_WIDTH-1:0]     new_min;
  logic [ADC_WIDTH-1:0]     new_max;
  logic [N_LOG2-1:0]        count;
  logic                     last;

  cs_edge_sync u_cs_sync (
    .clk      (clk_in),
    .rst      (reset),
    .async_in (CS),
    .pulse    (strobe)
  );

  // Square via magnitude so -128 squares to 16384 without a signed multiplier.
  assign s           = $signed({1'b0, ADC_value} - (ADC_WIDTH + 1)'(OFFSET));
  assign mag         = s[ADC_WIDTH] ? ADC_WIDTH'(-s) : s[ADC_WIDTH-1:0];
  assign sq_full     = mag * mag;
  assign sum_final   = sum + {{N_LOG2{s[ADC_WIDTH]}}, s};
  assign sumsq_final = sumsq + {{(SUMSQ_W - PROD_W){1'b0}}, sq_full};
  assign new_min     = (ADC_value < run_min) ? ADC_value : run_min;
  assign new_max     = (ADC_value > run_max) ? ADC_value : run_max;
  assign last        = &count;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: if (strobe) state_next = ST_ACCUM;
        ST_ACCUM: if (strobe && last) state_next = ST_DONE;
        ST_DONE:  state_next = ST_ACCUM;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sum          <= '0;
      sumsq        <= '0;
      count        <= '0;
      run_min      <= '1;
      run_max      <= '0;
      mean         <= '0;
      mean_sq      <= '0;
      peak_max     <= '0;
      peak_min     <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (enable && strobe) begin
            sum     <= sum_final;
            sumsq   <= sumsq_final;
            run_min <= new_min;
            run_max <= new_max;
            count   <= count + 1'b1;
            if (last) begin
              mean         <= sum_final[N_LOG2 +: ADC_WIDTH];
              mean_sq      <= sumsq_final[N_LOG2 +: SQ_WIDTH];
              peak_max     <= new_max;
              peak_min     <= new_min;
              result_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // A strobe landing here becomes sample 0 of the next window.
          if (enable && strobe) begin
            sum     <= {{N_LOG2{s[ADC_WIDTH]}}, s};
            sumsq   <= {{(SUMSQ_W - PROD_W){1'b0}}, sq_full};
            run_min <= ADC_value;
            run_max <= ADC_value;
            count   <= N_LOG2'(1);
          end else begin
            sum     <= '0;
            sumsq   <= '0;
            run_min <= '1;
            run_max <= '0;
            count   <= '0;
          end
        end
        default: begin
          sum     <= '0;
          sumsq   <= '0;
          run_min <= '1;
          run_max <= '0;
          count   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_window_accumulator.sv
// ============================================================================
// tb_adc_window_accumulator : directed windows with a queued scoreboard
// checked by an independent result monitor.               Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_window_accumulator;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        CS;
  logic [7:0]  ADC_value;
  logic [7:0]  mean;
  logic [14:0] mean_sq;
  logic [7:0]  peak_max;
  logic [7:0]  peak_min;
  logic        result_valid;

  typedef struct {
    logic [7:0]  mean;
    logic [14:0] msq;
    logic [7:0]  pmax;
    logic [7:0]  pmin;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_cyc[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  adc_window_accumulator #(.N_LOG2(6), .OFFSET(128)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .enable       (enable),
    .CS           (CS),
    .ADC_value    (ADC_value),
    .mean         (mean),
    .mean_sq      (mean_sq),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .result_valid (result_valid)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input logic [7:0] m, input logic [14:0] q,
                          input logic [7:0] mx, input logic [7:0] mn);
    exp_t x;
    x.mean = m; x.msq = q; x.pmax = mx; x.pmin = mn;
    exp_q.push_back(x);
  endtask

  // One CS period: 8 cycles high, 8 low (16 cycles per conversion).
  task automatic strobe(input logic [7:0] val);
    @(negedge clk_in);
    ADC_value = val;
    CS = 1'b1;
    repeat (8) @(negedge clk_in);
    CS = 1'b0;
    repeat (7) @(negedge clk_in);
  endtask

  task automatic send(input logic [7:0] val, input int n);
    for (int i = 0; i < n; i++) strobe(val);
  endtask

  task automatic rearm();
    @(negedge clk_in);
    enable = 1'b0;
    repeat (4) @(negedge clk_in);
    enable = 1'b1;
  endtask

  always @(negedge clk_in) begin
    if (result_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("mean",     int'(mean),     int'(e.mean));
        chk("mean_sq",  int'(mean_sq),  int'(e.msq));
        chk("peak_max", int'(peak_max), int'(e.pmax));
        chk("peak_min", int'(peak_min), int'(e.pmin));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; CS = 1'b0; ADC_value = 8'd0;
    repeat (3) @(negedge clk_in);
    chk("reset_mean",     int'(mean),         0);
    chk("reset_mean_sq",  int'(mean_sq),      0);
    chk("reset_peak_max", int'(peak_max),     0);
    chk("reset_peak_min", int'(peak_min),     0);
    chk("reset_valid",    int'(result_valid), 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk_in);

    // 1: mid-scale constant, prime strobe is the same value
    push_exp(8'd0, 15'd0, 8'd128, 8'd128);
    send(8'd128, 65);

    // 2: discarded prime of 0, then full-scale
    rearm();
    push_exp(8'd127, 15'd16129, 8'd255, 8'd255);
    strobe(8'd0);
    send(8'd255, 64);

    // 3: alternating extremes: sum -32 floors to -1, sumsq/64 = 16256.5
    rearm();
    push_exp(8'hFF, 15'd16256, 8'd255, 8'd0);
    strobe(8'd77);
    for (int i = 0; i < 32; i++) begin
      strobe(8'd0);
      strobe(8'd255);
    end

    // 4: partial window abandoned, then a fresh prime plus 64 samples
    rearm();
    strobe(8'd0);
    send(8'd100, 30);
    rearm();
    push_exp(8'hE4, 15'd784, 8'd100, 8'd100);
    strobe(8'd0);
    send(8'd100, 64);

    // 5: asynchronous reset mid-window clears outputs before the next edge
    rearm();
    strobe(8'd0);
    send(8'd90, 20);
    @(posedge clk_in);
    #3 reset = 1'b1;
    #1;
    chk("midreset_mean",     int'(mean),     0);
    chk("midreset_mean_sq",  int'(mean_sq),  0);
    chk("midreset_peak_max", int'(peak_max), 0);
    chk("midreset_peak_min", int'(peak_min), 0);
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    push_exp(8'd0, 15'd4, 8'd130, 8'd126);
    strobe(8'd200);
    send(8'd130, 32);
    send(8'd126, 32);

    // 6: back-to-back windows with a single prime
    rearm();
    pulse_cyc.delete();
    push_exp(8'd72, 15'd5184, 8'd200, 8'd200);
    push_exp(8'hB8, 15'd5184, 8'd56, 8'd56);
    strobe(8'd0);
    send(8'd200, 64);
    send(8'd56, 64);
    repeat (4) @(negedge clk_in);
    chk("b2b_pulse_count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2)
      chk("b2b_pulse_gap", pulse_cyc[1] - pulse_cyc[0], 64 * 16);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_in);
    chk("results_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
